// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared types, timing defaults and width helpers for the SPI frame scheduler
package spi_sched_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, DONE, GAP} state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_MAX_BYTES      = 2;
    localparam int DEF_SETUP_CYCLES   = 4;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    function automatic int len_w(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // One counter is shared by SETUP, WAIT and GAP, so it must cover the longest of them.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// rtl/spi_frame_scheduler_if.sv - requester and spi_master signal bundle for the frame scheduler
interface spi_frame_scheduler_if
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int LEN_W     = len_w(MAX_BYTES),
    parameter int IDX_W     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*LEN_W-1:0]       req_len;
    logic [NUM_REQ*MAX_BYTES*8-1:0] req_data;
    logic [NUM_REQ-1:0]             ack;
    logic                           err;
    logic [MAX_BYTES*8-1:0]         rsp_data;
    logic [IDX_W-1:0]               grant_id;
    logic                           busy;
    logic                           spi_start;
    logic [7:0]                     spi_tx_data;
    logic [7:0]                     spi_rx_data;
    logic                           spi_tx_ready;
    logic                           spi_done;
    logic                           ss;

    modport master (
        input  req, req_len, req_data, spi_rx_data, spi_tx_ready, spi_done,
        output ack, err, rsp_data, grant_id, busy, spi_start, spi_tx_data, ss
    );

    modport slave (
        output req, req_len, req_data, spi_rx_data, spi_tx_ready, spi_done,
        input  ack, err, rsp_data, grant_id, busy, spi_start, spi_tx_data, ss
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational round-robin pick starting one past the last grant
module spi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Scan farthest-first so the nearest requester after ptr overwrites and wins.
    always_comb begin
        logic [IDX_W-1:0] j;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                grant_idx   = j;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// rtl/spi_frame_scheduler.sv - round-robin framing of multi-byte requests onto one spi_master byte engine
module spi_frame_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int MAX_BYTES      = DEF_MAX_BYTES,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_frame_scheduler_if.master bus
);

    localparam int LEN_W = len_w(MAX_BYTES);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int FW    = 8 * MAX_BYTES;
    localparam int CNT_W = cnt_w(SETUP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [FW-1:0]      frame_q, frame_n, rsp_q, rsp_n;
    logic [LEN_W-1:0]   remaining_q, remaining_n;
    logic [IDX_W-1:0]   ptr_q, ptr_n, grant_q, grant_n;
    logic               tflag_q, tflag_n, ss_q, ss_n, start_q, start_n;
    logic               err_q, err_n, busy_q, busy_n;
    logic [7:0]         tx_q, tx_n;
    logic [NUM_REQ-1:0] ack_q, ack_n;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [LEN_W-1:0]   sel_len;
    logic [FW-1:0]      sel_data;

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (bus.req),
        .ptr        (ptr_q),
        .grant_idx  (arb_idx),
        .grant_valid(arb_valid)
    );

    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_len  = bus.req_len[i*LEN_W +: LEN_W];
                sel_data = bus.req_data[i*FW +: FW];
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        frame_n     = frame_q;
        rsp_n       = rsp_q;
        remaining_n = remaining_q;
        ptr_n       = ptr_q;
        grant_n     = grant_q;
        tflag_n     = tflag_q;
        ss_n        = ss_q;
        tx_n        = tx_q;
        busy_n      = busy_q;
        start_n     = 1'b0;
        ack_n       = '0;
        err_n       = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_n     = arb_idx;
                    ptr_n       = arb_idx;
                    busy_n      = 1'b1;
                    rsp_n       = '0;
                    tflag_n     = 1'b0;
                    frame_n     = sel_data;
                    cnt_n       = '0;
                    remaining_n = (sel_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len;
                    if (sel_len == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = SETUP;
                        ss_n    = 1'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) state_n = SEND;
                else                                    cnt_n   = cnt_q + 1'b1;
            end
            SEND: begin
                if (bus.spi_tx_ready) begin
                    start_n = 1'b1;
                    tx_n    = frame_q[FW-1 -: 8];
                    cnt_n   = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.spi_done) begin
                    rsp_n       = FW'({rsp_q, bus.spi_rx_data});
                    frame_n     = frame_q << 8;
                    remaining_n = remaining_q - 1'b1;
                    state_n     = (remaining_q == LEN_W'(1)) ? DONE : SEND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tflag_n = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ss_n           = 1'b1;
                ack_n[grant_q] = 1'b1;
                err_n          = tflag_q;
                cnt_n          = '0;
                // The DONE cycle is the first gap cycle.
                if (GAP_CYCLES <= 1) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    state_n = GAP;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 2)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            rsp_q       <= '0;
            remaining_q <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            tflag_q     <= 1'b0;
            ss_q        <= 1'b1;
            tx_q        <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            ack_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            frame_q     <= frame_n;
            rsp_q       <= rsp_n;
            remaining_q <= remaining_n;
            ptr_q       <= ptr_n;
            grant_q     <= grant_n;
            tflag_q     <= tflag_n;
            ss_q        <= ss_n;
            tx_q        <= tx_n;
            busy_q      <= busy_n;
            start_q     <= start_n;
            ack_q       <= ack_n;
            err_q       <= err_n;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.rsp_data    = rsp_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.spi_start   = start_q;
    assign bus.spi_tx_data = tx_q;
    assign bus.ss          = ss_q;

endmodule
